// File: rtl/bayer_capture_pkg.sv
// rtl/bayer_capture_pkg.sv - shared capture state encoding and default geometry
package bayer_capture_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SOF   = 2'd1,
    WAIT_FRISE = 2'd2,
    CAPTURE    = 2'd3
  } cap_state_t;

  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/bayer_round_sat.sv
// rtl/bayer_round_sat.sv - registered round-to-nearest and saturate of a raw sample to 8 bits
module bayer_round_sat #(
  parameter int inBits = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [inBits-1:0] sample,
  output logic              pixel_valid,
  output logic [7:0]        pixel
);

  localparam int SHIFT = inBits - 8;
  localparam logic [inBits:0] HALF = (inBits + 1)'(1) << (SHIFT - 1);

  logic [inBits:0] sum;
  logic [8:0]      scaled;

  // One extra bit so a carry out of the top sample bit shows up as overflow.
  assign sum    = {1'b0, sample} + HALF;
  assign scaled = 9'(sum >> SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_valid <= 1'b0;
      pixel       <= 8'd0;
    end else begin
      pixel_valid <= sample_valid;
      if (sample_valid) pixel <= scaled[8] ? 8'hFF : scaled[7:0];
    end
  end

endmodule

// File: rtl/bayer_capture.sv
// rtl/bayer_capture.sv - frame/line-valid Bayer ingest with crop, rounding and frame sequencing
module bayer_capture
  import bayer_capture_pkg::*;
#(
  parameter int width  = DEF_WIDTH,
  parameter int height = DEF_HEIGHT,
  parameter int xStart = 0,
  parameter int yStart = 0,
  parameter int inBits = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iFval,
  input  logic              iLval,
  input  logic [inBits-1:0] iData,
  input  logic              iEnable,
  input  logic              iContinuous,
  output logic [7:0]        oData,
  output logic              oValid,
  output logic              oNewFrame,
  output logic              oDone,
  output logic              oBusy,
  output logic              oShortLine,
  output logic              oShortFrame,
  output logic [15:0]       oFrameCnt
);

  localparam logic [CNT_W-1:0] X_LO   = CNT_W'(xStart);
  localparam logic [CNT_W-1:0] X_LEN  = CNT_W'(width);
  localparam logic [CNT_W-1:0] X_HI   = CNT_W'(xStart + width);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(xStart + width - 1);
  localparam logic [CNT_W-1:0] Y_LO   = CNT_W'(yStart);
  localparam logic [CNT_W-1:0] Y_LEN  = CNT_W'(height);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(yStart + height - 1);

  cap_state_t        state;
  logic              fval_r, lval_r, fval_d, lval_d, en_d;
  logic [inBits-1:0] data_r;
  logic [CNT_W-1:0]  col_cnt, row_cnt, col_off, row_off;
  logic              pix, fval_rise, fval_fall, lval_fall, en_rise;
  logic              col_hit, row_hit, capturing, keep, last_pix, line_short;
  logic              stop, hold_idle, done_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fval_r <= 1'b0;
      lval_r <= 1'b0;
      data_r <= '0;
      fval_d <= 1'b0;
      lval_d <= 1'b0;
      en_d   <= 1'b0;
    end else begin
      fval_r <= iFval;
      lval_r <= iLval;
      data_r <= iData;
      fval_d <= fval_r;
      lval_d <= lval_r;
      en_d   <= iEnable;
    end
  end

  assign pix       = fval_r & lval_r;
  assign fval_rise = fval_r & ~fval_d;
  assign fval_fall = ~fval_r & fval_d;
  assign lval_fall = ~lval_r & lval_d;
  assign en_rise   = iEnable & ~en_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (lval_fall)  col_cnt <= '0;
      else if (pix)   col_cnt <= col_cnt + CNT_W'(1);
      if (fval_rise)  row_cnt <= '0;
      else if (lval_fall) row_cnt <= row_cnt + CNT_W'(1);
    end
  end

  // Offsets wrap below the window start, so one unsigned compare covers both bounds.
  assign col_off    = col_cnt - X_LO;
  assign row_off    = row_cnt - Y_LO;
  assign col_hit    = col_off < X_LEN;
  assign row_hit    = row_off < Y_LEN;
  assign capturing  = (state == CAPTURE) || (state == WAIT_FRISE && fval_rise);
  assign keep       = pix & capturing & col_hit & row_hit;
  assign last_pix   = keep && (col_cnt == X_LAST) && (row_cnt == Y_LAST);
  assign line_short = lval_fall && row_hit && (col_cnt < X_HI);
  assign stop       = !iContinuous || !iEnable;
  assign oBusy      = (state != IDLE);

  bayer_round_sat #(.inBits(inBits)) u_round (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (keep),
    .sample       (data_r),
    .pixel_valid  (oValid),
    .pixel        (oData)
  );

  // hold_idle keeps a finished single shot parked until iEnable is dropped and re-raised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold_idle   <= 1'b0;
      oNewFrame   <= 1'b0;
      done_pipe   <= 1'b0;
      oDone       <= 1'b0;
      oFrameCnt   <= 16'd0;
      oShortLine  <= 1'b0;
      oShortFrame <= 1'b0;
    end else begin
      oNewFrame <= 1'b0;
      done_pipe <= last_pix;
      oDone     <= done_pipe;
      if (done_pipe) oFrameCnt <= oFrameCnt + 16'd1;
      if (!iEnable) hold_idle <= 1'b0;
      if (en_rise) begin
        oShortLine  <= 1'b0;
        oShortFrame <= 1'b0;
      end
      if (state == CAPTURE && line_short) oShortLine <= 1'b1;
      case (state)
        IDLE: if (iEnable && !hold_idle) state <= WAIT_SOF;
        WAIT_SOF: begin
          if (!iEnable)     state <= IDLE;
          else if (!fval_r) state <= WAIT_FRISE;
        end
        WAIT_FRISE: begin
          if (!iEnable) state <= IDLE;
          else if (fval_rise) begin
            oNewFrame <= 1'b1;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (last_pix || fval_fall) begin
            if (!last_pix) oShortFrame <= 1'b1;
            state     <= stop ? IDLE : WAIT_SOF;
            hold_idle <= stop & iEnable;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
